mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port, byte-lane data memory between the instruction-fetch path and the load/store path of the MIPS core.
- Accepts one access at a time, drives the memory port, and returns read data after a fixed latency.
- Sits between the PC controller / datapath and the memory model, replacing the direct inst_addr/mem_addr connections.
- Data accesses have priority, with a starvation guard so instruction fetch always makes progress.

Parameters:
MEM_LATENCY, 2, cycles from read-address presentation to valid mem_data_out; legal range 1..15.
STARVE_LIMIT, 3, maximum consecutive data grants while if_req is pending before fetch is forced; legal range 1..15.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_b  in  1  asynchronous, active-low reset.
halted  in  1  core halted; while high, no new grants are issued.
if_req  in  1  fetch request; held high until if_gnt.
if_addr  in  32  fetch byte address.
if_gnt  out  1  fetch accepted this cycle.
if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
if_rdata  out  32  fetched instruction word.
d_req  in  1  data request; held high until d_gnt.
d_we  in  1  1 = store, 0 = load.
d_addr  in  32  data byte address.
d_wdata  in  32  store data.
d_gnt  out  1  data access accepted this cycle.
d_rvalid  out  1  one-cycle pulse; d_rdata is valid (loads only).
d_rdata  out  32  load data.
mem_addr  out  32  memory address.
mem_data_in  out  8x[0:3]  memory write byte lanes.
mem_write_en  out  1  memory write strobe.
mem_data_out  in  8x[0:3]  memory read byte lanes.

Behaviour:
- Reset: state=IDLE, cnt=0, streak=0, owner=IF. if_rvalid, d_rvalid, if_gnt, d_gnt, mem_write_en are all 0. if_rdata, d_rdata, mem_addr are 0.
- States are IDLE and READ.
- Grants are issued only in IDLE with halted=0, and are combinational in the request cycle.
- Arbitration:
  - Only one of d_req, if_req high: grant that requester.
  - Both high: grant data if streak<STARVE_LIMIT, else grant fetch.
- Streak counter:
  - Increments, saturating at STARVE_LIMIT, on a data grant while if_req=1.
  - Clears on any fetch grant, or on any cycle with if_req=0.
- In IDLE:
  - mem_addr = winner's address, or the held address if no grant.
  - mem_data_in[0..3] = d_wdata[31:24], [23:16], [15:8], [7:0].
  - Byte-lane order is big-endian in both directions.
- Store (d_gnt & d_we):
  - mem_write_en=1 for exactly the grant cycle.
  - No rvalid is generated; the state remains IDLE.
  - Back-to-back stores run one per cycle.
- Read grant in cycle T:
  - Latch address and owner; enter READ with cnt=MEM_LATENCY-1.
  - mem_addr holds the latched address through cycle T+MEM_LATENCY.
  - At the posedge ending cycle T+MEM_LATENCY, capture {mem_data_out[0],[1],[2],[3]} into the owner's rdata register.
  - The owner's rvalid is high in cycle T+MEM_LATENCY+1; the state returns to IDLE at that same edge.
  - A new grant is allowed in the rvalid cycle, giving read throughput of one per MEM_LATENCY+1 cycles.
- In READ, no grants are issued, mem_write_en=0, and requests stay pending.
- Each rdata register holds its last value until that requester's next read completes.
- halted rising during READ: the in-flight read completes and delivers rvalid. No further grants are issued until halted=0.
- Reset asserted mid-read: abort immediately to reset values; no rvalid is emitted after reset release.
- A requester dropping req without a grant is legal; no state change results.
- mem_write_en is never asserted outside a d_gnt cycle.

Decomposition:
- Package mem_arb_pkg contains:
  - state enum {IDLE, READ}
  - owner enum {OWN_IF, OWN_D}
  - WORD_W=32, LANES=4
  - functions pack_lanes(word)->lanes and unpack_lanes(lanes)->word, big-endian
- Sub-module arb_pick: combinational two-requester priority selector with starvation override.
  - Inputs: if_req, d_req, streak_full, enable.
  - Outputs: grant_if, grant_d.

Test Plan (MEM_LATENCY=2, STARVE_LIMIT=3):
1. Fetch only: if_req with if_addr=0x40 at T, memory word 0x20080005 -> if_gnt at T; mem_addr=0x40 for cycles T..T+2; if_rvalid=1 at T+3 with if_rdata=0x20080005.
2. Store then load: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_write_en=1 for exactly 1 cycle with lanes DE,AD,BE,EF; then load 0x100 -> d_rvalid 3 cycles after grant, d_rdata=0xDEADBEEF.
3. Contention: if_req and d_req both held high continuously -> grant order D,D,D,IF,D,D,D,IF; streak clears after each IF grant.
4. halted=1 asserted during READ -> in-flight rvalid still arrives; no gnt for 10 cycles; after halted=0, the pending request is granted in the next cycle.
5. Reset: rst_b low one cycle after a read grant -> all outputs 0 immediately (asynchronous); no rvalid after release; a fresh request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and big-endian lane helpers for the memory arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef logic [7:0] lanes_t [LANES];

    // Lane 0 carries the most significant byte in both directions.
    function automatic void pack_lanes(input logic [WORD_W-1:0] word, output lanes_t lanes);
        for (int i = 0; i < LANES; i++) begin
            lanes[i] = word[WORD_W-1-8*i -: 8];
        end
    endfunction

    function automatic void unpack_lanes(input lanes_t lanes, output logic [WORD_W-1:0] word);
        word = '0;
        for (int i = 0; i < LANES; i++) begin
            word[WORD_W-1-8*i -: 8] = lanes[i];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick
// Brief    : Two-requester selector, data first unless fetch is being starved.
// Revision : 1.0
// ============================================================================
module arb_pick (
    input  logic if_req,
    input  logic d_req,
    input  logic streak_full,
    input  logic enable,
    output logic grant_if,
    output logic grant_d
);

    assign grant_d  = enable & d_req  & ~(if_req & streak_full);
    assign grant_if = enable & if_req & ~(d_req & ~streak_full);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares the single-port byte-lane memory between fetch and load/store.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              halted,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic [WORD_W-1:0] mem_addr,
    output logic [7:0]        mem_data_in  [0:LANES-1],
    output logic              mem_write_en,
    input  logic [7:0]        mem_data_out [0:LANES-1]
);

    localparam logic [3:0] c_cnt_init   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] c_streak_max = 4'(STARVE_LIMIT);

    state_t            state_q,     state_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic [3:0]        streak_q,    streak_d;
    owner_t            owner_q,     owner_d;
    logic [WORD_W-1:0] addr_q,      addr_d;
    logic [WORD_W-1:0] if_rdata_q,  if_rdata_d;
    logic [WORD_W-1:0] d_rdata_q,   d_rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q,  d_rvalid_d;

    logic              w_enable;
    logic              w_streak_full;
    logic              w_grant_if;
    logic              w_grant_d;
    logic [WORD_W-1:0] w_rword;
    lanes_t            w_wlanes;

    // Grants are combinational, so they are also masked while reset is held.
    assign w_enable      = (state_q == IDLE) && !halted && rst_b;
    assign w_streak_full = (streak_q >= c_streak_max);

    arb_pick u_arb_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .streak_full (w_streak_full),
        .enable      (w_enable),
        .grant_if    (w_grant_if),
        .grant_d     (w_grant_d)
    );

    always_comb begin
        unpack_lanes(mem_data_out, w_rword);
    end

    always_comb begin
        pack_lanes(d_wdata, w_wlanes);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            streak_q    <= 4'd0;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    addr_d  = d_addr;
                    owner_d = OWN_D;
                    if (!d_we) begin
                        state_d = READ;
                        cnt_d   = c_cnt_init;
                    end
                end else if (w_grant_if) begin
                    addr_d  = if_addr;
                    owner_d = OWN_IF;
                    state_d = READ;
                    cnt_d   = c_cnt_init;
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d  = w_rword;
                        if_rvalid_d = 1'b1;
                    end else begin
                        d_rdata_d  = w_rword;
                        d_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Streak counts data wins while fetch is waiting; it holds during READ.
    always_comb begin
        streak_d = streak_q;
        if (w_grant_if || !if_req) begin
            streak_d = 4'd0;
        end else if (w_grant_d && (streak_q < c_streak_max)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_comb begin
        mem_addr = addr_q;
        if (w_grant_d) begin
            mem_addr = d_addr;
        end else if (w_grant_if) begin
            mem_addr = if_addr;
        end
        mem_write_en = w_grant_d & d_we;
        for (int i = 0; i < LANES; i++) begin
            mem_data_in[i] = ((state_q == IDLE) && rst_b) ? w_wlanes[i] : 8'h00;
        end
    end

    assign if_gnt    = w_grant_if;
    assign d_gnt     = w_grant_d;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed and random checks of the arbiter against a cycle-count model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ML = 2;
    localparam int SL = 3;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        halted;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in  [0:3];
    logic        mem_write_en;
    logic [7:0]  mem_data_out [0:3];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(ML), .STARVE_LIMIT(SL)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .halted       (halted),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    // Memory environment: 1 KiB of bytes, read data reflects the address ML cycles ago.
    logic [7:0] mem   [0:1023];
    logic [9:0] ahist [1:ML];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_data_out[i] = mem[ahist[ML] + 10'(i)];
        end
    end

    // Reference model state, word-addressed.
    logic [31:0] ref_mem [0:255];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc;
    int          done_at;
    int          streak;
    bit          have_rd;
    owner_t      rd_owner;
    logic [31:0] rd_data;
    logic [31:0] held_addr;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
    logic [31:0] e_addr;
    bit          e_gd, e_gi, e_rv_if, e_rv_d, e_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        streak     = 0;
        have_rd    = 1'b0;
        done_at    = 0;
        held_addr  = '0;
        e_if_rdata = '0;
        e_d_rdata  = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_if_gnt"},    32'(if_gnt),       32'd0);
        chk({tag, "_d_gnt"},     32'(d_gnt),        32'd0);
        chk({tag, "_we"},        32'(mem_write_en), 32'd0);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid),    32'd0);
        chk({tag, "_d_rvalid"},  32'(d_rvalid),     32'd0);
        chk({tag, "_if_rdata"},  if_rdata,          32'd0);
        chk({tag, "_d_rdata"},   d_rdata,           32'd0);
        chk({tag, "_mem_addr"},  mem_addr,          32'd0);
        for (int i = 0; i < 4; i++) chk({tag, "_lane"}, 32'(mem_data_in[i]), 32'd0);
    endtask

    // Evaluate the expected outputs for the current cycle and compare.
    task automatic settle();
        #1;
        e_idle  = (cyc >= done_at);
        e_rv_if = have_rd && (cyc == done_at) && (rd_owner == OWN_IF);
        e_rv_d  = have_rd && (cyc == done_at) && (rd_owner == OWN_D);
        if (e_rv_if) e_if_rdata = rd_data;
        if (e_rv_d)  e_d_rdata  = rd_data;
        e_gd   = e_idle && !halted && d_req && (!if_req || streak < SL);
        e_gi   = e_idle && !halted && if_req && !e_gd;
        e_addr = e_gd ? d_addr : (e_gi ? if_addr : held_addr);
        chk("if_gnt",    32'(if_gnt),       32'(e_gi));
        chk("d_gnt",     32'(d_gnt),        32'(e_gd));
        chk("mem_we",    32'(mem_write_en), 32'(e_gd && d_we));
        chk("mem_addr",  mem_addr,          e_addr);
        chk("if_rvalid", 32'(if_rvalid),    32'(e_rv_if));
        chk("d_rvalid",  32'(d_rvalid),     32'(e_rv_d));
        chk("if_rdata",  if_rdata,          e_if_rdata);
        chk("d_rdata",   d_rdata,           e_d_rdata);
        if (e_gd && d_we) begin
            for (int i = 0; i < 4; i++) chk("store_lane", 32'(mem_data_in[i]), 32'(d_wdata[31-8*i -: 8]));
        end
    endtask

    task automatic advance();
        logic [9:0] a_s;
        logic       we_s;
        logic [7:0] l_s [0:3];
        a_s  = mem_addr[9:0];
        we_s = mem_write_en;
        for (int i = 0; i < 4; i++) l_s[i] = mem_data_in[i];
        if (have_rd && cyc == done_at) have_rd = 1'b0;
        if (e_gd || e_gi) held_addr = e_addr;
        if (e_gd && d_we) begin
            ref_mem[d_addr[9:2]] = d_wdata;
        end else if (e_gd || e_gi) begin
            have_rd  = 1'b1;
            rd_owner = e_gd ? OWN_D : OWN_IF;
            rd_data  = ref_mem[e_addr[9:2]];
            done_at  = cyc + ML + 1;
        end
        if (e_gi || !if_req) streak = 0;
        else if (e_gd && streak < SL) streak++;
        cyc++;
        @(posedge clk);
        #1;
        if (we_s) for (int i = 0; i < 4; i++) mem[a_s + 10'(i)] = l_s[i];
        for (int k = ML; k > 1; k--) ahist[k] = ahist[k-1];
        ahist[1] = a_s;
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  seq;
        int          ng;
        int          nrv;

        rst_b = 1'b0; halted = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int k = 1; k <= ML; k++) ahist[k] = '0;
        for (int a = 0; a < 256; a++) begin
            w = (a == 16) ? 32'h2008_0005 : $urandom;
            ref_mem[a] = w;
            for (int b = 0; b < 4; b++) mem[10'(a * 4 + b)] = w[31-8*b -: 8];
        end
        model_reset();
        cyc = 0;

        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_b = 1'b1;

        // Fetch only from 0x40.
        if_req = 1'b1; if_addr = 32'h40;
        settle(); chk("t1_gnt", 32'(if_gnt), 32'd1); advance();
        if_req = 1'b0;
        step(); step();
        settle(); chk("t1_rdata", if_rdata, 32'h2008_0005); chk("t1_rvalid", 32'(if_rvalid), 32'd1); advance();

        // Store then load 0x100.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        settle();
        chk("t2_we", 32'(mem_write_en), 32'd1);
        chk("t2_l0", 32'(mem_data_in[0]), 32'hDE);
        chk("t2_l1", 32'(mem_data_in[1]), 32'hAD);
        chk("t2_l2", 32'(mem_data_in[2]), 32'hBE);
        chk("t2_l3", 32'(mem_data_in[3]), 32'hEF);
        advance();
        d_req = 1'b0; d_we = 1'b0;
        settle(); chk("t2_we_off", 32'(mem_write_en), 32'd0); advance();
        d_req = 1'b1;
        step();
        d_req = 1'b0;
        step(); step();
        settle(); chk("t2_rvalid", 32'(d_rvalid), 32'd1); chk("t2_rdata", d_rdata, 32'hDEAD_BEEF); advance();

        // Continuous contention: expect D,D,D,IF,D,D,D,IF.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h80; d_addr = 32'h300;
        seq = '0; ng = 0;
        for (int n = 0; n < 60 && ng < 8; n++) begin
            settle();
            if (if_gnt || d_gnt) begin
                seq = {seq[6:0], if_gnt};
                ng++;
            end
            advance();
            if_addr = {22'd0, 8'($urandom), 2'b00};
            d_addr  = {22'd0, 8'($urandom), 2'b00};
        end
        chk("t3_order", 32'(seq), 32'h11);
        if_req = 1'b0; d_req = 1'b0;
        repeat (4) step();

        // Halt during an in-flight load with fetch pending.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; if_req = 1'b1; if_addr = 32'h84;
        settle(); chk("t4_dgnt", 32'(d_gnt), 32'd1); advance();
        d_req = 1'b0; halted = 1'b1;
        nrv = 0;
        for (int n = 0; n < 10; n++) begin
            settle();
            chk("t4_no_gnt", 32'({if_gnt, d_gnt}), 32'd0);
            if (d_rvalid) nrv++;
            advance();
        end
        chk("t4_rvalid_cnt", 32'(nrv), 32'd1);
        halted = 1'b0;
        settle(); chk("t4_resume_gnt", 32'(if_gnt), 32'd1); advance();
        if_req = 1'b0;
        repeat (4) step();

        // Reset one cycle after a read grant, requests held meanwhile.
        if_req = 1'b1; if_addr = 32'h44;
        step();
        d_req = 1'b1; d_we = 1'b1;
        rst_b = 1'b0;
        #1;
        chk_zero("t5_reset");
        model_reset();
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        rst_b = 1'b1;
        repeat (5) step();
        if_req = 1'b1; if_addr = 32'h40;
        step();
        if_req = 1'b0;
        step(); step();
        settle(); chk("t5_fresh_rdata", if_rdata, 32'h2008_0005); advance();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = {22'd0, 8'($urandom), 2'b00};
            end else if (if_req && $urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
                d_wdata = $urandom;
            end else if (d_req && $urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
            halted = ($urandom_range(0, 9) == 0);
            step();
            if (e_gi) if_req = 1'b0;
            if (e_gd) d_req  = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
